// File: rtl/io_bus_ctrl_pkg.sv
// Shared constants and FSM encoding for the io_bus_ctrl data-bus sequencer.
package io_bus_ctrl_pkg;

    localparam logic [3:0]  IO_REGION_DEFAULT = 4'h8;

    localparam logic [1:0]  ACC_BYTE = 2'b00;
    localparam logic [1:0]  ACC_HALF = 2'b01;
    localparam logic [1:0]  ACC_WORD = 2'b10;

    // Address bit selecting the local interrupt register inside IO space.
    localparam int unsigned IRQ_REG_ADDR_BIT = 4;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StStrobe  = 2'd1,
        StCapture = 2'd2
    } state_e;

endpackage

// File: rtl/io_irq_latch.sv
// Sticky FIFO interrupt pending bits with per-source enables; only built when
// IO_IRQ_LATCH_EN is defined.
`ifdef IO_IRQ_LATCH_EN
module io_irq_latch (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       in_irq_i,
    input  logic       out_irq_i,
    input  logic       wr_en_i,
    input  logic [3:0] wdata_i,
    output logic [3:0] rdata_o,
    output logic       irq_o
);
    logic [1:0] pend_q, pend_d;
    logic [1:0] en_q;
    logic [1:0] irq_prev_q;
    logic [1:0] rise;
    logic [1:0] clr;

    assign rise = {out_irq_i, in_irq_i} & ~irq_prev_q;
    assign clr  = wr_en_i ? wdata_i[3:2] : 2'b00;

    // Set is applied after clear so a coincident edge is never lost.
    always_comb begin
        pend_d = (pend_q & ~clr) | rise;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pend_q     <= 2'b00;
            en_q       <= 2'b00;
            irq_prev_q <= 2'b00;
        end else begin
            pend_q     <= pend_d;
            irq_prev_q <= {out_irq_i, in_irq_i};
            if (wr_en_i) begin
                en_q <= wdata_i[1:0];
            end
        end
    end

    assign rdata_o = {pend_q, en_q};
    assign irq_o   = |(pend_q & en_q);

endmodule
`endif

// File: rtl/io_bus_ctrl.sv
// Data-bus sequencer: memory accesses pass straight through, USB FIFO accesses run a
// 3-cycle strobe sequence. Define IO_IRQ_LATCH_EN for the latched interrupt register.
module io_bus_ctrl
    import io_bus_ctrl_pkg::*;
#(
    parameter logic [3:0] IO_REGION      = IO_REGION_DEFAULT,
    parameter bit         FIFO_BYTE_ONLY = 1'b1
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        req_rd_i,
    input  logic        req_wr_i,
    input  logic [31:0] req_addr_i,
    input  logic [1:0]  req_acc_i,
    input  logic [31:0] req_wdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        mem_rd_o,
    output logic        mem_wr_o,
    input  logic [31:0] mem_rdata_i,
    output logic        fifo_sel_o,
    output logic        fifo_rd_o,
    output logic        fifo_wr_o,
    output logic [1:0]  fifo_addr_o,
    output logic [7:0]  fifo_wdata_o,
    input  logic [7:0]  fifo_rdata_i,
    input  logic        fifo_in_irq_i,
    input  logic        fifo_out_irq_i,
    output logic        irq_o
);
    state_e      state_q;
    logic        sel_q, rd_q, wr_q;
    logic        was_read_q, local_q;
    logic [1:0]  addr_q;
    logic [7:0]  wdata_q;

    logic        is_io, any_req, illegal, accept, local_hit;
    logic [3:0]  local_rdata;
    logic [31:0] io_data;
    logic        unused_bits;

    assign is_io   = (req_addr_i[31:28] == IO_REGION);
    assign any_req = req_rd_i | req_wr_i;
    assign illegal = (req_rd_i & req_wr_i)
                   | (is_io & any_req & FIFO_BYTE_ONLY & (req_acc_i != ACC_BYTE));

    // Reset gates the combinational handshake so stall drops with the strobes.
    assign accept  = rstn_i & (state_q == StIdle) & is_io & any_req & ~illegal;
    assign err_o   = rstn_i & (state_q == StIdle) & illegal;
    assign stall_o = accept | (state_q == StStrobe);

    // Simultaneous read and write is resolved as a write.
    assign mem_rd_o = req_rd_i & ~req_wr_i & ~is_io;
    assign mem_wr_o = req_wr_i & ~is_io;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= StIdle;
            sel_q      <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            was_read_q <= 1'b0;
            local_q    <= 1'b0;
            addr_q     <= 2'b00;
            wdata_q    <= 8'h00;
        end else begin
            sel_q <= 1'b0;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q    <= StStrobe;
                        sel_q      <= ~local_hit;
                        rd_q       <= ~local_hit & req_rd_i;
                        wr_q       <= ~local_hit & req_wr_i;
                        was_read_q <= req_rd_i;
                        local_q    <= local_hit;
                        addr_q     <= req_addr_i[3:2];
                        wdata_q    <= req_wdata_i[7:0];
                    end
                end
                StStrobe:  state_q <= StCapture;
                StCapture: state_q <= StIdle;
                default:   state_q <= StIdle;
            endcase
        end
    end

    assign fifo_sel_o   = sel_q;
    assign fifo_rd_o    = rd_q;
    assign fifo_wr_o    = wr_q;
    assign fifo_addr_o  = addr_q;
    assign fifo_wdata_o = wdata_q;

    // Read data from the slave is valid in CAPTURE and forwarded the same cycle.
    always_comb begin
        io_data = 32'h0;
        if ((state_q == StCapture) && was_read_q) begin
            io_data = local_q ? {28'h0, local_rdata} : {24'h0, fifo_rdata_i};
        end
    end

    assign rdata_o = mem_rdata_i | io_data;

`ifdef IO_IRQ_LATCH_EN
    logic local_wr;

    assign local_hit = req_addr_i[IRQ_REG_ADDR_BIT];
    assign local_wr  = (state_q == StStrobe) & local_q & ~was_read_q;

    io_irq_latch u_irq_latch (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .in_irq_i  (fifo_in_irq_i),
        .out_irq_i (fifo_out_irq_i),
        .wr_en_i   (local_wr),
        .wdata_i   (wdata_q[3:0]),
        .rdata_o   (local_rdata),
        .irq_o     (irq_o)
    );
`else
    assign local_hit   = 1'b0;
    assign local_rdata = 4'h0;
    assign irq_o       = fifo_in_irq_i | fifo_out_irq_i;
`endif

    assign unused_bits = ^{req_addr_i[27:4], req_addr_i[1:0], req_wdata_i[31:8]};

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Bench for io_bus_ctrl: transaction-level model checked every cycle plus directed
// literal expectations; covers IO_IRQ_LATCH_EN when that macro is defined.
module tb_io_bus_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_rd, req_wr;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_acc;
    logic        stall, err, mem_rd, mem_wr, irq;
    logic [31:0] rdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        fifo_sel, fifo_rd, fifo_wr;
    logic [1:0]  fifo_addr;
    logic [7:0]  fifo_wdata;
    logic [7:0]  fifo_rdata = 8'h0;
    logic        fifo_in_irq, fifo_out_irq;

    localparam logic [31:0] MEM_VAL  = 32'hCAFE_0123;
    localparam logic [7:0]  FIFO_VAL = 8'h7E;

    int checks = 0;
    int passes = 0;
    int sel_cnt = 0;

    // Transaction model: phase 0 = free, 1 = strobe cycle, 2 = data cycle.
    int          phase = 0;
    logic        t_rd = 1'b0, t_wr = 1'b0, t_local = 1'b0;
    logic [1:0]  t_addr = 2'b00;
    logic [7:0]  t_wd = 8'h00;
    logic [1:0]  pend = 2'b00, en = 2'b00, prev = 2'b00;
    logic        mem_rd_seen = 1'b0, fifo_rd_seen = 1'b0;

    always #5 clk = ~clk;

    io_bus_ctrl dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .req_rd_i       (req_rd),
        .req_wr_i       (req_wr),
        .req_addr_i     (req_addr),
        .req_acc_i      (req_acc),
        .req_wdata_i    (req_wdata),
        .stall_o        (stall),
        .rdata_o        (rdata),
        .err_o          (err),
        .mem_rd_o       (mem_rd),
        .mem_wr_o       (mem_wr),
        .mem_rdata_i    (mem_rdata),
        .fifo_sel_o     (fifo_sel),
        .fifo_rd_o      (fifo_rd),
        .fifo_wr_o      (fifo_wr),
        .fifo_addr_o    (fifo_addr),
        .fifo_wdata_o   (fifo_wdata),
        .fifo_rdata_i   (fifo_rdata),
        .fifo_in_irq_i  (fifo_in_irq),
        .fifo_out_irq_i (fifo_out_irq),
        .irq_o          (irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [1:0] acc, input logic [31:0] wd);
        req_rd    = rd;
        req_wr    = wr;
        req_addr  = addr;
        req_acc   = acc;
        req_wdata = wd;
    endtask

    // Slave responders: data appears the cycle after a read enable/strobe.
    always @(negedge clk) begin
        mem_rd_seen  = mem_rd;
        fifo_rd_seen = fifo_rd;
    end

    always @(posedge clk) begin
        #1;
        mem_rdata  = mem_rd_seen ? MEM_VAL : 32'h0;
        fifo_rdata = fifo_rd_seen ? FIFO_VAL : 8'h00;
    end

    always @(posedge clk or negedge rstn) begin : model
        logic io, ok;
        if (!rstn) begin
            phase <= 0;
            pend  <= 2'b00;
            en    <= 2'b00;
            prev  <= 2'b00;
        end else begin
            io = (req_addr[31:28] == 4'h8);
            ok = !(req_rd && req_wr) && (req_acc == 2'b00);
`ifdef IO_IRQ_LATCH_EN
            if (phase == 1 && t_local && t_wr) begin
                en   <= t_wd[1:0];
                pend <= (pend & ~t_wd[3:2]) | ({fifo_out_irq, fifo_in_irq} & ~prev);
            end else begin
                pend <= pend | ({fifo_out_irq, fifo_in_irq} & ~prev);
            end
            prev <= {fifo_out_irq, fifo_in_irq};
`endif
            case (phase)
                0: if ((req_rd || req_wr) && io && ok) begin
                    phase   <= 1;
                    t_rd    <= req_rd;
                    t_wr    <= req_wr;
                    t_addr  <= req_addr[3:2];
                    t_wd    <= req_wdata[7:0];
`ifdef IO_IRQ_LATCH_EN
                    t_local <= req_addr[4];
`else
                    t_local <= 1'b0;
`endif
                end
                1: phase <= 2;
                default: phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin : cmp
        logic io, anyr, bad, e_stall, e_err, e_irq;
        logic [31:0] io_val;
        io      = (req_addr[31:28] == 4'h8);
        anyr    = req_rd | req_wr;
        bad     = (req_rd & req_wr) | (io & anyr & (req_acc != 2'b00));
        e_err   = rstn && phase == 0 && bad;
        e_stall = (rstn && phase == 0 && anyr && io && !bad) || phase == 1;
        io_val  = 32'h0;
        if (phase == 2 && t_rd)
            io_val = t_local ? {28'h0, pend, en} : {24'h0, fifo_rdata};
`ifdef IO_IRQ_LATCH_EN
        e_irq = |(pend & en);
`else
        e_irq = fifo_in_irq | fifo_out_irq;
`endif
        chk("cyc_stall", stall, e_stall);
        chk("cyc_err", err, e_err);
        chk("cyc_mem", {mem_rd, mem_wr}, {req_rd & ~req_wr & ~io, req_wr & ~io});
        chk("cyc_strobe", {fifo_sel, fifo_rd, fifo_wr},
            {phase == 1 && !t_local, phase == 1 && !t_local && t_rd,
             phase == 1 && !t_local && t_wr});
        chk("cyc_rdata", rdata, mem_rdata | io_val);
        chk("cyc_irq", irq, e_irq);
        if (phase == 1 && !t_local) begin
            chk("cyc_faddr", fifo_addr, t_addr);
            chk("cyc_fwdata", fifo_wdata, t_wd);
        end
        if (fifo_sel) sel_cnt++;
    end

    initial begin
        rstn = 1'b0;
        fifo_in_irq = 1'b0;
        fifo_out_irq = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        #3;
        chk("rst_stall", stall, 0);
        chk("rst_err", err, 0);
        chk("rst_strobes", {fifo_sel, fifo_rd, fifo_wr}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_irq", irq, 0);
        step(); step();
        rstn = 1'b1;
        step();

        // Memory load
        drive(1'b1, 1'b0, 32'h0000_0010, 2'b10, 32'h0);
        #3;
        chk("mem_ld_rd", mem_rd, 1);
        chk("mem_ld_stall", stall, 0);
        step();
        drive(1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        #3;
        chk("mem_ld_rdata", rdata, MEM_VAL);
        chk("mem_ld_nosel", sel_cnt, 0);
        step();

        // FIFO byte store
        drive(1'b0, 1'b1, 32'h8000_0004, 2'b00, 32'h1234_56A5);
        #3;
        chk("st_accept_stall", stall, 1);
        chk("st_accept_nosel", fifo_sel, 0);
        step(); #3;
        chk("st_strobe", {fifo_sel, fifo_rd, fifo_wr}, 3'b101);
        chk("st_addr", fifo_addr, 2'b01);
        chk("st_wdata", fifo_wdata, 8'hA5);
        chk("st_strobe_stall", stall, 1);
        step(); #3;
        chk("st_capture_stall", stall, 0);
        chk("st_capture_sel", fifo_sel, 0);
        step();
        drive(1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        step();
        chk("st_one_strobe", sel_cnt, 1);

        // FIFO byte load
        drive(1'b1, 1'b0, 32'h8000_000C, 2'b00, 32'h0);
        #3;
        chk("ld_accept_stall", stall, 1);
        step(); #3;
        chk("ld_strobe", {fifo_sel, fifo_rd, fifo_wr}, 3'b110);
        chk("ld_addr", fifo_addr, 2'b11);
        step(); #3;
        chk("ld_capture_rdata", rdata, 32'h0000_007E);
        chk("ld_capture_stall", stall, 0);
        step();
        drive(1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        #3;
        chk("ld_after_rdata", rdata, 0);
        step();

        // Illegal word IO load
        drive(1'b1, 1'b0, 32'h8000_0000, 2'b10, 32'h0);
        #3;
        chk("ill_err", err, 1);
        chk("ill_stall", stall, 0);
        chk("ill_rdata", rdata, 0);
        chk("ill_nosel", fifo_sel, 0);
        step();
        drive(1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        #3;
        chk("ill_err_pulse", err, 0);
        step();

        // Read and write together on memory: resolved as a write, flagged
        drive(1'b1, 1'b1, 32'h0000_0020, 2'b00, 32'h55);
        #3;
        chk("rw_err", err, 1);
        chk("rw_mem", {mem_rd, mem_wr}, 2'b01);
        step();
        drive(1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        step();
        chk("ill_no_strobe", sel_cnt, 2);

        // Request held for six cycles: exactly two complete IO accesses
        drive(1'b1, 1'b0, 32'h8000_0008, 2'b00, 32'h0);
        repeat (6) step();
        drive(1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        step();
        chk("b2b_strobes", sel_cnt, 4);

        // Reset during STROBE, then a clean access after release
        drive(1'b0, 1'b1, 32'h8000_0008, 2'b00, 32'h0000_003C);
        step();
        #1;
        rstn = 1'b0;
        #1;
        chk("rst_mid_strobes", {fifo_sel, fifo_rd, fifo_wr}, 0);
        chk("rst_mid_stall", stall, 0);
        step(); step();
        rstn = 1'b1;
        #3;
        chk("post_rst_accept", stall, 1);
        step(); #3;
        chk("post_rst_strobe", {fifo_sel, fifo_rd, fifo_wr}, 3'b101);
        chk("post_rst_wdata", fifo_wdata, 8'h3C);
        step(); step();
        drive(1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        step();
        chk("post_rst_count", sel_cnt, 5);

`ifdef IO_IRQ_LATCH_EN
        drive(1'b0, 1'b1, 32'h8000_0010, 2'b00, 32'h3);
        step(); step(); step();
        drive(1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        #3;
        chk("irq_before_pulse", irq, 0);
        step();
        fifo_in_irq = 1'b1;
        step();
        fifo_in_irq = 1'b0;
        #3;
        chk("irq_latched", irq, 1);
        step();
        drive(1'b1, 1'b0, 32'h8000_0010, 2'b00, 32'h0);
        step(); step(); #3;
        chk("irq_reg_read", rdata, 32'h7);
        step();
        drive(1'b0, 1'b1, 32'h8000_0010, 2'b00, 32'h4);
        step(); step(); step();
        drive(1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        #3;
        chk("irq_cleared", irq, 0);
        chk("irq_no_fifo_strobe", sel_cnt, 5);
`else
        fifo_in_irq = 1'b1;
        #1;
        chk("irq_in", irq, 1);
        fifo_in_irq = 1'b0;
        fifo_out_irq = 1'b1;
        #1;
        chk("irq_out", irq, 1);
        fifo_out_irq = 1'b0;
        #1;
        chk("irq_none", irq, 0);
`endif
        step(); step();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
